// File: rtl/serial_pattern_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM encoding and default sizes.
package serial_pattern_pkg;

  localparam int unsigned DefPatternW = 4;
  localparam int unsigned DefCntW     = 8;

  // Canonical stimulus word for the 1010 sequence detector.
  localparam logic [DefPatternW-1:0] DEF_PATTERN = 4'b1010;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StGap   = 2'b10,
    StDone  = 2'b11
  } tx_state_e;

endpackage

// File: rtl/pattern_shifter.sv
// Parallel-load, MSB-first shift register with a bit-index counter.
// Keeps a copy of the loaded word so each repetition can be reloaded without the top.
module pattern_shifter
  import serial_pattern_pkg::*;
#(
  parameter int unsigned PATTERN_W = DefPatternW
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 clear_i,
  input  logic                 load_i,
  input  logic                 shift_i,
  input  logic [PATTERN_W-1:0] data_i,
  output logic                 cur_bit_o,
  output logic                 next_bit_o,
  output logic                 last_bit_o
);

  localparam int unsigned IdxW = $clog2(PATTERN_W);
  localparam logic [IdxW-1:0] IdxTop = IdxW'(PATTERN_W - 1);

  logic [PATTERN_W-1:0] pat_q;
  logic [PATTERN_W-1:0] sr_q;
  logic [IdxW-1:0]      idx_q;

  // Load, advance, or reload the word once the last bit has been shifted out.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      pat_q <= '0;
      sr_q  <= '0;
      idx_q <= '0;
    end else if (load_i) begin
      pat_q <= data_i;
      sr_q  <= data_i;
      idx_q <= IdxTop;
    end else if (shift_i) begin
      if (idx_q == '0) begin
        sr_q  <= pat_q;
        idx_q <= IdxTop;
      end else begin
        sr_q  <= {sr_q[PATTERN_W-2:0], 1'b0};
        idx_q <= idx_q - 1'b1;
      end
    end
  end

  assign cur_bit_o  = sr_q[PATTERN_W-1];
  assign last_bit_o = (idx_q == '0);
  // Bit that will be current after the next shift (wraps to the MSB of the stored word).
  assign next_bit_o = last_bit_o ? pat_q[PATTERN_W-1] : sr_q[PATTERN_W-2];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter: shifts a captured word out MSB-first, repeat_n times,
// then pulses done. All outputs are registered.
// Optional build macro SERIAL_TX_GAP_EN inserts GAP_LEN idle cycles between repetitions.
module serial_pattern_tx
  import serial_pattern_pkg::*;
#(
  parameter int unsigned PATTERN_W = DefPatternW,
  parameter int unsigned CNT_W     = DefCntW,
  parameter int unsigned GAP_LEN   = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [PATTERN_W-1:0] pattern_i,
  input  logic [CNT_W-1:0]     repeat_n_i,
  input  logic                 abort_i,
  output logic                 x_o,
  output logic                 x_valid_o,
  output logic                 frame_sop_o,
  output logic                 busy_o,
  output logic                 done_o
);

  tx_state_e        state_q;
  logic [CNT_W-1:0] reps_q;
  logic             x_q;
  logic             x_valid_q;
  logic             sop_q;
  logic             busy_q;
  logic             done_q;

`ifdef SERIAL_TX_GAP_EN
  localparam int unsigned GapW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  logic [GapW-1:0] gap_q;
`else
  logic unused_gap_len;
  assign unused_gap_len = ^GAP_LEN;
`endif

  logic sh_cur_bit;
  logic sh_next_bit;
  logic sh_last_bit;
  logic sh_load;
  logic sh_shift;
  logic sh_clear;

  // Shifter commands mirror the FSM decisions taken on the same edge.
  assign sh_load  = (state_q == StIdle) && start_i && (repeat_n_i != '0);
  assign sh_shift = (state_q == StShift) && !abort_i;
  assign sh_clear = abort_i && ((state_q == StShift) || (state_q == StGap));

  pattern_shifter #(
    .PATTERN_W (PATTERN_W)
  ) u_shifter (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .clear_i    (sh_clear),
    .load_i     (sh_load),
    .shift_i    (sh_shift),
    .data_i     (pattern_i),
    .cur_bit_o  (sh_cur_bit),
    .next_bit_o (sh_next_bit),
    .last_bit_o (sh_last_bit)
  );

  // Control FSM with repeat counter and registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      reps_q    <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      sop_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SERIAL_TX_GAP_EN
      gap_q     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          x_q       <= 1'b0;
          x_valid_q <= 1'b0;
          sop_q     <= 1'b0;
          busy_q    <= 1'b0;
          if (start_i) begin
            if (repeat_n_i != '0) begin
              state_q   <= StShift;
              reps_q    <= repeat_n_i;
              x_q       <= pattern_i[PATTERN_W-1];
              x_valid_q <= 1'b1;
              sop_q     <= 1'b1;
              busy_q    <= 1'b1;
            end else begin
              // Zero-length transfer still completes with a done pulse.
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end

        StShift: begin
          if (abort_i) begin
            state_q   <= StIdle;
            reps_q    <= '0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            sop_q     <= 1'b0;
            busy_q    <= 1'b0;
          end else if (sh_last_bit) begin
            reps_q <= reps_q - 1'b1;
            if (reps_q == CNT_W'(1)) begin
              state_q   <= StDone;
              x_q       <= 1'b0;
              x_valid_q <= 1'b0;
              sop_q     <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end else begin
`ifdef SERIAL_TX_GAP_EN
              if (GAP_LEN != 0) begin
                state_q   <= StGap;
                gap_q     <= GapW'(GAP_LEN - 1);
                x_q       <= 1'b0;
                x_valid_q <= 1'b0;
                sop_q     <= 1'b0;
              end else begin
                x_q   <= sh_next_bit;
                sop_q <= 1'b1;
              end
`else
              x_q   <= sh_next_bit;
              sop_q <= 1'b1;
`endif
            end
          end else begin
            x_q   <= sh_next_bit;
            sop_q <= 1'b0;
          end
        end

`ifdef SERIAL_TX_GAP_EN
        StGap: begin
          if (abort_i) begin
            state_q   <= StIdle;
            reps_q    <= '0;
            gap_q     <= '0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            sop_q     <= 1'b0;
            busy_q    <= 1'b0;
          end else if (gap_q == '0) begin
            // Shifter already holds the reloaded word; present its MSB.
            state_q   <= StShift;
            x_q       <= sh_cur_bit;
            x_valid_q <= 1'b1;
            sop_q     <= 1'b1;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
`endif

        StDone: begin
          state_q   <= StIdle;
          x_q       <= 1'b0;
          x_valid_q <= 1'b0;
          sop_q     <= 1'b0;
          busy_q    <= 1'b0;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifndef SERIAL_TX_GAP_EN
  logic unused_cur_bit;
  assign unused_cur_bit = sh_cur_bit;
`endif

  assign x_o         = x_q;
  assign x_valid_o   = x_valid_q;
  assign frame_sop_o = sop_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule
